// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, FIFO entry layout and write-source selection for the
// register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  kill;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_PIPE,
    SEL_FIFO
  } wb_sel_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// In-order multdiv result buffer with per-entry kill bits and a registered
// mask of destination registers still owed a write.
module wb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        ctrl_reset_n,
  input  logic                        push,
  input  logic [REG_ADDR_W-1:0]       push_rd,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  input  logic                        kill_en,
  input  logic [REG_ADDR_W-1:0]       kill_rd,
  output wb_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic [NUM_REGS-1:0]         live_mask
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t           mem_q [DEPTH];
  wb_entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;

  function automatic logic slot_live(input int unsigned idx,
                                     input logic [PTR_W-1:0] hd,
                                     input logic [CNT_W-1:0] cnt);
    logic [PTR_W-1:0] off;
    off = PTR_W'(idx) - hd;
    return CNT_W'(off) < cnt;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    mask_d  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill_en && slot_live(i, head_q, count_q) && mem_q[i].rd == kill_rd)
        mem_d[i].kill = 1'b1;
    end
    // A same-cycle pipe write to the pushed rd is younger, so the new entry is born killed.
    if (push) begin
      mem_d[tail_q] = '{kill: kill_en && (kill_rd == push_rd), rd: push_rd, data: push_data};
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop)
      head_d = head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_live(i, head_d, count_d) && !mem_d[i].kill)
        mask_d = mask_d | reg_onehot(mem_d[i].rd);
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mask_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mask_q  <= mask_d;
    end
  end

  assign head      = mem_q[head_q];
  assign count     = count_q;
  assign live_mask = mask_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writebacks and buffered multdiv results onto the single
// register-file write port; pipeline wins, starvation forces a bubble.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0]     pipe_data,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0]     data_writeReg,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic                  pipe_stall
);

  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             head;
  logic [CNT_W-1:0]      count;
  logic                  fifo_empty, pipe_eff, enq, pop;
  wb_sel_e               sel;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  stall_d, we_d;
  logic [REG_ADDR_W-1:0] reg_d;
  logic [DATA_W-1:0]     data_d;

  assign fifo_empty = (count == '0);
  assign md_ready   = (count < CNT_W'(DEPTH));
  assign pipe_eff   = pipe_we && (pipe_rd != ZERO_REG) && !pipe_stall;
  assign enq        = md_valid && md_ready && (md_rd != ZERO_REG);
  assign pop        = (sel == SEL_FIFO);

  wb_fifo #(.DEPTH(DEPTH)) u_wb_fifo (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .push         (enq),
    .push_rd      (md_rd),
    .push_data    (md_data),
    .pop          (pop),
    .kill_en      (pipe_eff),
    .kill_rd      (pipe_rd),
    .head         (head),
    .count        (count),
    .live_mask    (pending_mask)
  );

  always_comb begin
    sel      = SEL_IDLE;
    starve_d = starve_q;
    we_d     = 1'b0;
    reg_d    = ctrl_writeReg;
    data_d   = data_writeReg;
    if (pipe_eff)
      sel = SEL_PIPE;
    else if (!fifo_empty)
      sel = SEL_FIFO;
    case (sel)
      SEL_PIPE: begin
        we_d   = 1'b1;
        reg_d  = pipe_rd;
        data_d = pipe_data;
        if (!fifo_empty)
          starve_d = starve_q + STARVE_W'(1);
      end
      SEL_FIFO: begin
        starve_d = '0;
        if (!head.kill) begin
          we_d   = 1'b1;
          reg_d  = head.rd;
          data_d = head.data;
        end
      end
      default: ;
    endcase
    // The counter clears on the forced pop, so the stall lasts exactly one cycle.
    stall_d = (starve_d >= STARVE_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      starve_q         <= '0;
      pipe_stall       <= 1'b0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      starve_q         <= starve_d;
      pipe_stall       <= stall_d;
      ctrl_writeEnable <= we_d;
      ctrl_writeReg    <= reg_d;
      data_writeReg    <= data_d;
    end
  end

  a_no_pipe_we_while_stalled : assert property (
    @(posedge clock) disable iff (!ctrl_reset_n) !(pipe_stall && pipe_we));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        ctrl_reset_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] pending_mask;
  logic        pipe_stall;

  int unsigned n_checks;
  int unsigned n_fail;

  regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .pipe_we          (pipe_we),
    .pipe_rd          (pipe_rd),
    .pipe_data        (pipe_data),
    .md_valid         (md_valid),
    .md_ready         (md_ready),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .pending_mask     (pending_mask),
    .pipe_stall       (pipe_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check_eq({tag, ".we"},   32'(ctrl_writeEnable), 32'd1);
    check_eq({tag, ".reg"},  32'(ctrl_writeReg), 32'(rd));
    check_eq({tag, ".data"}, data_writeReg, data);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".we"},    32'(ctrl_writeEnable), 32'd0);
    check_eq({tag, ".reg"},   32'(ctrl_writeReg), 32'd0);
    check_eq({tag, ".data"},  data_writeReg, 32'd0);
    check_eq({tag, ".mask"},  pending_mask, 32'd0);
    check_eq({tag, ".stall"}, 32'(pipe_stall), 32'd0);
    check_eq({tag, ".ready"}, 32'(md_ready), 32'd1);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    ctrl_reset_n = 1'b0;
    pipe_we      = 1'b0;
    pipe_rd      = '0;
    pipe_data    = '0;
    md_valid     = 1'b0;
    md_rd        = '0;
    md_data      = '0;

    #3;
    check_reset_outputs("reset");
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    tick();

    // Idle push: r5 written one cycle after push, mask bit5 for one cycle
    md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h1234_5678;
    tick();
    md_valid = 1'b0;
    check_eq("idle.we0", 32'(ctrl_writeEnable), 32'd0);
    check_eq("idle.mask_set", pending_mask, 32'h0000_0020);
    tick();
    check_write("idle.wr", 5'd5, 32'h1234_5678);
    check_eq("idle.mask_clr", pending_mask, 32'd0);
    tick();
    check_eq("idle.after", 32'(ctrl_writeEnable), 32'd0);

    // Priority: three pipe writes to r3, then r7 from the FIFO
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hA;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'hB;
    tick();
    md_valid = 1'b0;
    check_write("prio.c0", 5'd3, 32'hA);
    check_eq("prio.mask", pending_mask, 32'h0000_0080);
    tick();
    check_write("prio.c1", 5'd3, 32'hA);
    tick();
    check_write("prio.c2", 5'd3, 32'hA);
    pipe_we = 1'b0;
    tick();
    check_write("prio.md", 5'd7, 32'hB);
    check_eq("prio.mask_clr", pending_mask, 32'd0);
    tick();

    // WAW kill, same-cycle: entry born killed
    pipe_we = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h2;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h1;
    tick();
    md_valid = 1'b0;
    check_write("waw.p0", 5'd9, 32'h2);
    check_eq("waw.mask0", pending_mask, 32'd0);
    tick();
    check_write("waw.p1", 5'd9, 32'h2);
    pipe_we = 1'b0;
    tick();
    check_eq("waw.killed_pop", 32'(ctrl_writeEnable), 32'd0);
    tick();
    check_eq("waw.empty", 32'(ctrl_writeEnable), 32'd0);

    // WAW kill of an older queued entry
    pipe_we = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h44;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h1;
    tick();
    md_valid = 1'b0;
    check_eq("waw2.mask_set", pending_mask, 32'h0000_0200);
    pipe_rd = 5'd9; pipe_data = 32'h2;
    tick();
    check_write("waw2.pipe", 5'd9, 32'h2);
    check_eq("waw2.mask_clr", pending_mask, 32'd0);
    pipe_we = 1'b0;
    tick();
    check_eq("waw2.killed_pop", 32'(ctrl_writeEnable), 32'd0);
    tick();

    // Full / back-pressure
    pipe_we = 1'b1; pipe_rd = 5'd1;
    for (int k = 0; k < 4; k++) begin
      check_eq("full.ready_pre", 32'(md_ready), 32'd1);
      pipe_data = 32'h100 + 32'(k);
      md_valid = 1'b1; md_rd = 5'(10 + k); md_data = 32'hC0 + 32'(k);
      tick();
      check_write("full.pipe", 5'd1, 32'h100 + 32'(k));
    end
    check_eq("full.ready0", 32'(md_ready), 32'd0);
    check_eq("full.mask", pending_mask, 32'h0000_3C00);
    md_rd = 5'd14; md_data = 32'hC4; pipe_data = 32'h104;
    tick();
    check_write("full.refused_pipe", 5'd1, 32'h104);
    check_eq("full.still_full", 32'(md_ready), 32'd0);
    pipe_we = 1'b0;
    tick();
    check_write("full.pop0", 5'd10, 32'hC0);
    check_eq("full.ready1", 32'(md_ready), 32'd1);
    check_eq("full.mask1", pending_mask, 32'h0000_3800);
    tick();
    md_valid = 1'b0;
    check_write("full.pop1", 5'd11, 32'hC1);
    check_eq("full.mask2", pending_mask, 32'h0000_7000);
    tick();
    check_write("full.pop2", 5'd12, 32'hC2);
    tick();
    check_write("full.pop3", 5'd13, 32'hC3);
    tick();
    check_write("full.pop4", 5'd14, 32'hC4);
    check_eq("full.mask_end", pending_mask, 32'd0);
    tick();

    // Starvation: one queued entry, pipe writes every cycle
    pipe_we = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h22;
    md_valid = 1'b1; md_rd = 5'd20; md_data = 32'hDEAD;
    tick();
    md_valid = 1'b0;
    check_eq("starve.stall0", 32'(pipe_stall), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("starve.stall", 32'(pipe_stall), (k == 8) ? 32'd1 : 32'd0);
      if (pipe_stall) pipe_we = 1'b0;
    end
    tick();
    check_write("starve.forced", 5'd20, 32'hDEAD);
    check_eq("starve.stall_drop", 32'(pipe_stall), 32'd0);
    pipe_we = 1'b0;
    tick();

    // r0: neither source writes, and pipe r0 does not block a pop
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h55;
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h66;
    tick();
    check_eq("r0.we", 32'(ctrl_writeEnable), 32'd0);
    check_eq("r0.mask", pending_mask, 32'd0);
    md_rd = 5'd6; md_data = 32'h66;
    tick();
    md_valid = 1'b0;
    check_eq("r0.we2", 32'(ctrl_writeEnable), 32'd0);
    tick();
    check_write("r0.pop_under_r0", 5'd6, 32'h66);
    pipe_we = 1'b0;
    tick();

    // Reset mid-operation with three entries queued
    pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h77;
    for (int k = 0; k < 3; k++) begin
      md_valid = 1'b1; md_rd = 5'(21 + k); md_data = 32'hE0 + 32'(k);
      tick();
    end
    md_valid = 1'b0; pipe_we = 1'b0;
    check_eq("rst.mask_before", pending_mask, 32'h00E0_0000);
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    check_reset_outputs("rst.async");
    @(negedge clock);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("rst.no_write", 32'(ctrl_writeEnable), 32'd0);
      check_eq("rst.mask", pending_mask, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
